// File: rtl/cs_rr_arbiter.sv
// ---------------------------------------------------------------------------
// cs_rr_arbiter
//
// Round-robin chip-select arbiter for eight requesters that share a single
// 3-to-8 select resource. Exactly one active-low select line is driven at a
// time. gnt_L uses the same encoding as the downstream decoder: one bit low
// for the owner, or all ones when nobody owns the resource. Consecutive
// owners are always separated by one all-high cycle. Each grant can
// optionally be cut off after HOLD_MAX cycles.
//
// Parameters
//   HOLD_MAX : maximum number of cycles one grant may last (0 = unlimited)
//   CNT_W    : hold-counter width, must satisfy 2**CNT_W > HOLD_MAX
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   synchronous active-high reset, overrides all inputs
//   en          in   global enable; low releases the owner and blocks grants
//   req[7:0]    in   active-high requests, held by a requester until served
//   done        in   owner finished; release on the next edge
//   gnt_L[7:0]  out  active-low one-hot grant, 8'hFF when idle
//   gnt_idx     out  index of the current or most recent owner
//   busy        out  high while a grant is active
//   timeout     out  one-cycle pulse when only the hold limit ended a grant
//   state_dbg_o out  current FSM state (IDLE=0, GRANT=1, GAP=2)
//
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module cs_rr_arbiter #(
   parameter int unsigned HOLD_MAX = 16,
   parameter int unsigned CNT_W    = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [7:0] req,
   input  logic       done,
   output logic [7:0] gnt_L,
   output logic [2:0] gnt_idx,
   output logic       busy,
   output logic       timeout,
   output logic [1:0] state_dbg_o
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_GAP   = 2'd2
   } state_e;

   localparam bit               HOLD_EN  = (HOLD_MAX != 0);
   localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);
   localparam logic [CNT_W-1:0] CNT_SAT  = '1;

   state_e           state_q, state_d;
   logic [2:0]       ptr_q, ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       gnt_l_q, gnt_l_d;
   logic [2:0]       idx_q, idx_d;
   logic             busy_q, busy_d;
   logic             tmo_q, tmo_d;

   // ------------------------------------------------------------------
   // Arbitration: rotate the request vector so that the bit at ptr lands
   // at position 0, pick the lowest set bit, then undo the rotation. The
   // 3-bit add wraps naturally from 7 back to 0.
   // ------------------------------------------------------------------
   logic [15:0] req_dbl;
   logic [7:0]  req_rot;
   logic [2:0]  rot_off;
   logic        arb_found;
   logic        arb_go;
   logic [2:0]  arb_winner;

   assign req_dbl    = {req, req} >> ptr_q;
   assign req_rot    = req_dbl[7:0];
   assign arb_found  = |req_rot;
   assign arb_go     = en & arb_found;
   assign arb_winner = ptr_q + rot_off;

   // Descending scan so the lowest set bit is the last one written.
   always_comb begin
      rot_off = 3'd0;
      for (int k = 7; k >= 0; k--) begin
         if (req_rot[k]) begin
            rot_off = 3'(k);
         end
      end
   end

   // ------------------------------------------------------------------
   // Release causes while a grant is active. The hold limit alone raises
   // timeout; if any other cause coincides, the release counts as normal.
   // ------------------------------------------------------------------
   logic owner_req;
   logic other_rel;
   logic hold_hit;

   assign owner_req = req[idx_q];
   assign other_rel = done | ~owner_req | ~en;
   assign hold_hit  = HOLD_EN && (cnt_q == HOLD_LIM);

   // ------------------------------------------------------------------
   // Next-state and next-output logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      gnt_l_d = gnt_l_q;
      idx_d   = idx_q;
      busy_d  = busy_q;
      tmo_d   = 1'b0;

      case (state_q)
         ST_IDLE, ST_GAP: begin
            gnt_l_d = 8'hFF;
            busy_d  = 1'b0;
            if (arb_go) begin
               state_d = ST_GRANT;
               idx_d   = arb_winner;
               gnt_l_d = ~(8'h01 << arb_winner);
               busy_d  = 1'b1;
               cnt_d   = CNT_W'(1);
            end else begin
               // GAP lasts one cycle only; with nothing to serve fall to IDLE.
               state_d = ST_IDLE;
            end
         end

         ST_GRANT: begin
            if (other_rel || hold_hit) begin
               state_d = ST_GAP;
               gnt_l_d = 8'hFF;
               busy_d  = 1'b0;
               // The owner just served becomes lowest priority next round.
               ptr_d   = idx_q + 3'd1;
               tmo_d   = hold_hit & ~other_rel;
            end else if (cnt_q != CNT_SAT) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         default: begin
            state_d = ST_IDLE;
            gnt_l_d = 8'hFF;
            busy_d  = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         ptr_q   <= 3'd0;
         cnt_q   <= '0;
         gnt_l_q <= 8'hFF;
         idx_q   <= 3'd0;
         busy_q  <= 1'b0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         gnt_l_q <= gnt_l_d;
         idx_q   <= idx_d;
         busy_q  <= busy_d;
         tmo_q   <= tmo_d;
      end
   end

   assign gnt_L       = gnt_l_q;
   assign gnt_idx     = idx_q;
   assign busy        = busy_q;
   assign timeout     = tmo_q;
   assign state_dbg_o = state_q;

   // ------------------------------------------------------------------
   // Structural invariants of the grant outputs
   // ------------------------------------------------------------------
   // At most one select line is low at any time.
   a_onehot_low: assert property (@(posedge clk) disable iff (rst)
      $countones(~gnt_l_q) <= 1);

   // busy mirrors whether any select line is low.
   a_busy_match: assert property (@(posedge clk) disable iff (rst)
      busy_q == (gnt_l_q != 8'hFF));

   // A disabled cycle never produces a grant on the following edge.
   a_en_block: assert property (@(posedge clk) disable iff (rst)
      !en |=> (gnt_l_q == 8'hFF));

   // timeout only appears while the lines are all high.
   a_tmo_idle: assert property (@(posedge clk) disable iff (rst)
      tmo_q |-> (gnt_l_q == 8'hFF));

endmodule

// File: tb/tb_cs_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cs_rr_arbiter
//
// Bench for cs_rr_arbiter. A behavioural model tracks who owns the select
// resource (owner number or none), the round-robin starting point and how
// long the current owner has held it, and derives the expected outputs from
// that every cycle. Directed scenarios pin exact literal values; a long
// random phase exercises the rest against the model.
// ---------------------------------------------------------------------------
module tb_cs_rr_arbiter;

   localparam int HOLD_MAX = 16;
   localparam int CNT_W    = 5;
   localparam int W        = 3;

   // ---------------- clock / reset / DUT ----------------
   logic       clk;
   logic       rst;
   logic       en;
   logic [7:0] req;
   logic       done;
   logic [7:0] gnt_L;
   logic [2:0] gnt_idx;
   logic       busy;
   logic       timeout;
   logic [1:0] state_dbg;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   cs_rr_arbiter #(
      .HOLD_MAX (HOLD_MAX),
      .CNT_W    (CNT_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .req         (req),
      .done        (done),
      .gnt_L       (gnt_L),
      .gnt_idx     (gnt_idx),
      .busy        (busy),
      .timeout     (timeout),
      .state_dbg_o (state_dbg)
   );

   // ---------------- scoreboard counters ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // m_owner: requester holding the resource, -1 when nobody does.
   // m_ptr:   requester with highest priority at the next arbitration.
   // m_held:  number of cycles the current owner has held the grant.
   int m_owner = -1;
   int m_last  = 0;
   int m_ptr   = 0;
   int m_held  = 0;
   bit m_tmo   = 1'b0;
   bit m_valid = 1'b0;
   bit m_other;
   bit m_limit;

   always @(posedge clk) begin
      if (rst) begin
         m_owner = -1;
         m_last  = 0;
         m_ptr   = 0;
         m_held  = 0;
         m_tmo   = 1'b0;
         m_valid = 1'b1;
      end else if (m_valid) begin
         if (m_owner >= 0) begin
            m_other = done || !req[m_owner] || !en;
            m_limit = (HOLD_MAX != 0) && (m_held == HOLD_MAX);
            m_tmo   = m_limit && !m_other;
            if (m_other || m_limit) begin
               m_ptr   = (m_owner + 1) % 8;
               m_owner = -1;
            end else begin
               m_held = m_held + 1;
            end
         end else begin
            m_tmo = 1'b0;
            if (en && req != 8'h00) begin
               for (int k = 0; k < 8; k++) begin
                  if (req[(m_ptr + k) % 8]) begin
                     m_owner = (m_ptr + k) % 8;
                     break;
                  end
               end
               m_last = m_owner;
               m_held = 1;
            end
         end
      end
   end

   function automatic logic [7:0] model_gnt_l();
      logic [7:0] sel;
      sel = 8'h00;
      if (m_owner >= 0) sel[m_owner] = 1'b1;
      return ~sel;
   endfunction

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (m_valid) begin
         check("gnt_L",   gnt_L,   model_gnt_l());
         check("gnt_idx", gnt_idx, m_last[2:0]);
         check("busy",    busy,    (m_owner >= 0));
         check("timeout", timeout, m_tmo);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive(input logic r, input logic e, input logic [7:0] q, input logic d);
      rst  = r;
      en   = e;
      req  = q;
      done = d;
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      drive(1'b1, 1'b0, 8'h00, 1'b0);
      step();
      step();
   endtask

   // ---------------- stimulus ----------------
   logic [W-1:0] exp_q[$];
   int nb;
   int n_ef;
   int n_tmo;

   initial begin
      drive(1'b1, 1'b0, 8'h00, 1'b0);

      // Reset values, then a single requester finishing on its 4th cycle.
      do_reset();
      check("rst_gnt_L",   gnt_L,   8'hFF);
      check("rst_gnt_idx", gnt_idx, 3'd0);
      check("rst_busy",    busy,    1'b0);
      check("rst_timeout", timeout, 1'b0);
      drive(1'b0, 1'b1, 8'h04, 1'b0);
      step();
      check("A_first_gnt", gnt_L, 8'hFB);
      check("A_model_gnt", model_gnt_l(), 8'hFB);
      nb = 0;
      for (int i = 1; i <= 5; i++) begin
         if (i > 1) step();
         if (busy) nb++;
         done = (i == 4);
         if (i == 5) begin
            check("A_release_gnt", gnt_L, 8'hFF);
            check("A_idx_hold",    gnt_idx, 3'd2);
            req  = 8'h00;
            done = 1'b0;
         end
      end
      check("A_busy_cycles", nb, 4);
      step();

      // All requesting, done every grant cycle: 0..7,0 with one-cycle gaps.
      do_reset();
      drive(1'b0, 1'b1, 8'hFF, 1'b1);
      exp_q = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
      for (int i = 1; i <= 17; i++) begin
         step();
         if (i % 2 == 1) begin
            check("B_busy_grant", busy, 1'b1);
            check("B_order", gnt_idx, exp_q.pop_front());
         end else begin
            check("B_gap_gnt", gnt_L, 8'hFF);
         end
      end
      drive(1'b0, 1'b1, 8'h00, 1'b0);
      step();

      // Wrap: serve 7, then 0 wins over 7 with req=8'h81.
      do_reset();
      drive(1'b0, 1'b1, 8'h80, 1'b1);
      step();
      check("C_gnt7", gnt_L, 8'h7F);
      req = 8'h81;
      step();
      check("C_gap", gnt_L, 8'hFF);
      step();
      check("C_wrap_gnt", gnt_L, 8'hFE);
      check("C_wrap_idx", gnt_idx, 3'd0);
      check("C_model_gnt", model_gnt_l(), 8'hFE);
      drive(1'b0, 1'b1, 8'h00, 1'b0);
      step();
      step();

      // Hold limit reached with no other cause: timeout pulse, then re-grant.
      do_reset();
      drive(1'b0, 1'b1, 8'h10, 1'b0);
      n_ef = 0;
      for (int i = 1; i <= 18; i++) begin
         step();
         if (i <= 17 && gnt_L == 8'hEF) n_ef++;
         if (i == 17) begin
            check("D_release_gnt", gnt_L, 8'hFF);
            check("D_timeout", timeout, 1'b1);
            check("D_model_tmo", m_tmo, 1'b1);
         end
         if (i == 18) begin
            check("D_regrant", gnt_L, 8'hEF);
            check("D_tmo_pulse", timeout, 1'b0);
            req = 8'h00;
         end
      end
      check("D_hold_cycles", n_ef, 16);
      step();
      step();

      // Hold limit coincides with done: release without timeout.
      do_reset();
      drive(1'b0, 1'b1, 8'h10, 1'b0);
      n_tmo = 0;
      for (int i = 1; i <= 17; i++) begin
         step();
         if (timeout) n_tmo++;
         if (i == 16) done = 1'b1;
         if (i == 17) begin
            check("E_release_gnt", gnt_L, 8'hFF);
            req  = 8'h00;
            done = 1'b0;
         end
      end
      check("E_no_timeout", n_tmo, 0);
      step();

      // en dropped for one cycle mid-grant, then reset mid-grant.
      do_reset();
      drive(1'b0, 1'b1, 8'h08, 1'b0);
      step();
      check("F_gnt3", gnt_L, 8'hF7);
      step();
      en = 1'b0;
      step();
      check("F_en_release", gnt_L, 8'hFF);
      check("F_en_no_tmo", timeout, 1'b0);
      en = 1'b1;
      step();
      check("F_regrant3", gnt_L, 8'hF7);
      rst = 1'b1;
      step();
      check("F_rst_gnt_L", gnt_L, 8'hFF);
      check("F_rst_idx",   gnt_idx, 3'd0);
      check("F_rst_busy",  busy, 1'b0);
      check("F_rst_tmo",   timeout, 1'b0);
      drive(1'b0, 1'b1, 8'hFF, 1'b0);
      step();
      check("F_first_after_rst", gnt_L, 8'hFE);
      check("F_first_idx", gnt_idx, 3'd0);

      // Random phase against the model.
      for (int i = 0; i < 4000; i++) begin
         step();
         rst  = ($urandom_range(0, 299) == 0);
         en   = ($urandom_range(0, 15) != 0);
         done = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 29) == 0) begin
            req = 8'h00;
         end else if ($urandom_range(0, 9) == 0) begin
            req = 8'($urandom_range(0, 255));
         end
      end

      drive(1'b0, 1'b0, 8'h00, 1'b0);
      step();
      step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
